// File: rtl/ifw_ctrl_fsm.sv
// Ifmap write controller: sequences one pass of rows from the input FIFO into the
// stage-0/stage-1 write counters, then waits for the downstream write FSM to drain.
module ifw_ctrl_fsm #(
    parameter int ROW_WIDTH   = 8,
    parameter int WRFSM_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ROW_WIDTH-1:0]   cfg_row_finalnum,
    input  logic                   din_fifo_valid,
    input  logic                   din_wr_stg0_last,
    input  logic                   din_wr_stg1_last,
    input  logic [WRFSM_WIDTH-1:0] din_wr_curr_state,
    output logic [2:0]             dout_ifw_curr_state,
    output logic                   dout_idle2start,
    output logic                   dout_row_last,
    output logic [ROW_WIDTH-1:0]   dout_row_cnt,
    output logic                   dout_wr_stg0_en,
    output logic                   dout_wr_stg1_en,
    output logic                   dout_fifo_rd,
    output logic                   dout_busy,
    output logic                   dout_done
);

    typedef enum logic [2:0] {
        IW_IDLE = 3'd0,
        IW_DLOD = 3'd1,
        IW_WABF = 3'd2,
        IW_RST  = 3'd3,
        IW_DONE = 3'd4
    } iw_state_e;

    localparam logic [WRFSM_WIDTH-1:0] WR_DONE = WRFSM_WIDTH'(4);

    iw_state_e              state_q, state_d;
    logic [ROW_WIDTH-1:0]   row_cnt_q, row_cnt_d;
    logic [ROW_WIDTH-1:0]   row_final_q, row_final_d;

    logic                   stg0_en;
    logic                   stg1_en;
    logic                   row_end;
    logic                   row_last;

    assign row_last = (row_cnt_q == row_final_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IW_IDLE;
            row_cnt_q   <= '0;
            row_final_q <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            row_final_q <= row_final_d;
        end
    end

    // Enables are gated by reset so the FIFO is never popped while reset is held,
    // even in the first reset cycle before the state register has cleared.
    always_comb begin
        state_d         = state_q;
        row_cnt_d       = row_cnt_q;
        row_final_d     = row_final_q;
        stg0_en         = 1'b0;
        stg1_en         = 1'b0;
        row_end         = 1'b0;
        dout_idle2start = 1'b0;
        dout_done       = 1'b0;

        case (state_q)
            IW_IDLE: begin
                if (start && !reset) begin
                    dout_idle2start = 1'b1;
                    state_d         = IW_DLOD;
                    row_final_d     = cfg_row_finalnum;
                    row_cnt_d       = '0;
                end
            end
            IW_DLOD: begin
                stg0_en = din_fifo_valid && !reset;
                stg1_en = stg0_en && din_wr_stg0_last;
                row_end = stg1_en && din_wr_stg1_last;
                if (row_end) begin
                    if (row_last) begin
                        state_d = IW_WABF;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_WIDTH'(1);
                    end
                end
            end
            IW_WABF: begin
                if (din_wr_curr_state == WR_DONE) begin
                    state_d = IW_RST;
                end
            end
            IW_RST: begin
                row_cnt_d = '0;
                state_d   = IW_DONE;
            end
            IW_DONE: begin
                dout_done = !reset;
                state_d   = IW_IDLE;
            end
            default: begin
                state_d = IW_IDLE;
            end
        endcase
    end

    assign dout_ifw_curr_state = state_q;
    assign dout_row_last       = row_last;
    assign dout_row_cnt        = row_cnt_q;
    assign dout_wr_stg0_en     = stg0_en;
    assign dout_fifo_rd        = stg0_en;
    assign dout_wr_stg1_en     = stg1_en;
    assign dout_busy           = (state_q != IW_IDLE) && !reset;

endmodule

// File: doc/ifw_ctrl_fsm.md
IFW_CTRL_FSM -- requirements
Module: ifw_ctrl_fsm

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 8, the width of the row counter and row final number.
REQ-002 SHALL have parameter WRFSM_WIDTH, default 3, the width of the write-FSM state input.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin one ifmap write pass.
REQ-006 cfg_row_finalnum  input  ROW_WIDTH  index of the last row; latched on start acceptance.
REQ-007 din_fifo_valid  input  1  upstream FIFO holds a data word.
REQ-008 din_wr_stg0_last  input  1  stage-0 write counter at its final value.
REQ-009 din_wr_stg1_last  input  1  stage-1 write counter at its final value.
REQ-010 din_wr_curr_state  input  WRFSM_WIDTH  current state of the downstream write counter FSM (WR_DONE=4).
REQ-011 dout_ifw_curr_state  output  3  current IW state.
REQ-012 dout_idle2start  output  1  start-accepted pulse to the write counter FSM.
REQ-013 dout_row_last  output  1  row counter equals the latched final row.
REQ-014 dout_row_cnt  output  ROW_WIDTH  current row index.
REQ-015 dout_wr_stg0_en  output  1  stage-0 and SRAM-address counter enable.
REQ-016 dout_wr_stg1_en  output  1  stage-1 counter enable.
REQ-017 dout_fifo_rd  output  1  FIFO pop strobe.
REQ-018 dout_busy  output  1  pass in progress.
REQ-019 dout_done  output  1  one-cycle pass-complete pulse.

Function
REQ-020 States SHALL be encoded IW_IDLE=0, IW_DLOD=1, IW_WABF=2, IW_RST=3, IW_DONE=4; dout_ifw_curr_state SHALL be the registered state.
REQ-021 IW_IDLE -> IW_DLOD when start=1; otherwise stay in IW_IDLE.
REQ-022 dout_idle2start SHALL be combinational: (state==IW_IDLE) & start.
REQ-023 On the IW_IDLE->IW_DLOD edge, cfg_row_finalnum SHALL be latched into a row_final register and row_cnt SHALL be 0.
REQ-024 dout_wr_stg0_en = dout_fifo_rd = (state==IW_DLOD) & din_fifo_valid; the FIFO pop and the stage-0 enable SHALL always be the same signal, with zero latency.
REQ-025 dout_wr_stg1_en = dout_wr_stg0_en & din_wr_stg0_last.
REQ-026 row_end = dout_wr_stg1_en & din_wr_stg1_last; on row_end, row_cnt SHALL increment by 1 unless dout_row_last=1, in which case it holds.
REQ-027 dout_row_last = (row_cnt == row_final), combinational from registers.
REQ-028 IW_DLOD -> IW_WABF on row_end & dout_row_last; otherwise stay.
REQ-029 While din_fifo_valid=0 in IW_DLOD, all enables SHALL be 0 and the state and row_cnt SHALL hold (stall).
REQ-030 In IW_WABF, all enables SHALL be 0; IW_WABF -> IW_RST when din_wr_curr_state==4; otherwise wait indefinitely.
REQ-031 IW_RST SHALL clear row_cnt to 0 and go to IW_DONE next cycle.
REQ-032 IW_DONE SHALL assert dout_done for exactly one cycle, then go to IW_IDLE.
REQ-033 dout_busy = (state != IW_IDLE).
REQ-034 start is ignored in every state other than IW_IDLE.
REQ-035 Illegal state encodings (5-7) SHALL go to IW_IDLE on the next cycle.
REQ-036 If cfg_row_finalnum=0, a single row SHALL complete the pass.

Reset
REQ-037 While reset=1: state=IW_IDLE, row_cnt=0, row_final=0, all enables=0, dout_busy=0, dout_done=0, dout_idle2start=0 (the start term is masked by reset).
REQ-038 Reset asserted mid-pass SHALL abort the pass with no dout_done pulse; the FIFO is not popped during reset.

Verification
REQ-039 Reset, then start=1 for 1 cycle with cfg_row_finalnum=2 -> dout_idle2start=1 that cycle, state=1 next cycle, dout_busy=1.
REQ-040 In DLOD with fifo_valid=1 and stg0_last/stg1_last driven by a model counter (stg0 final=3, stg1 final=1) -> exactly 24 fifo_rd pulses, row_cnt sequence 0,1,2, then state=2.
REQ-041 fifo_valid toggling 1/0 every cycle during DLOD -> enables track valid exactly, pop count is unchanged at 24, and row_cnt never advances on a valid=0 cycle.
REQ-042 In WABF, hold din_wr_curr_state=1 for 10 cycles, then drive 4 -> state stays 2 for those 10 cycles, then 3, 4, 0 on successive cycles; dout_done is high only in state 4.
REQ-043 Assert reset in DLOD at row_cnt=1 -> next cycle state=0, row_cnt=0, and no dout_done pulse.
REQ-044 start=1 while in DLOD, and cfg_row_finalnum=0 -> start is ignored in DLOD; in the finalnum=0 pass, one row_end moves the state to WABF.
